// File: rtl/aer_enc_pkg.sv
// Shared types and constants for the AER rate encoder: FSM states, LFSR mask,
// default tick address and the LFSR next-state helper.
package aer_enc_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EVAL,
      ST_REQ,
      ST_REL,
      ST_FIN
   } enc_state_t;

   localparam logic [15:0] LFSR_MASK     = 16'hB400;
   localparam logic [11:0] DEF_TICK_ADDR = 12'hFFF;
   localparam logic [1:0]  SPIKE_PREFIX  = 2'b00;

   // Galois step: shift right, fold the mask in when the bit shifted out is 1.
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
   endfunction

endpackage

// File: rtl/aer_lfsr16.sv
// 16-bit Galois LFSR used as the per-pixel random draw; reloads SEED on load.
module aer_lfsr16
   import aer_enc_pkg::*;
#(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        load,
   input  logic        advance,
   output logic [15:0] state
);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST)          state <= SEED;
      else if (load)    state <= SEED;
      else if (advance) state <= lfsr_next(state);
   end

endmodule

// File: rtl/aer_rate_encoder.sv
// Rate-coding AER transmitter: scans a stored image T times, spiking each pixel
// against an LFSR draw, with a tick after each scan. AER_ACK_SYNC_EN adds an ACK synchronizer.
module aer_rate_encoder
   import aer_enc_pkg::*;
#(
   parameter int          N         = 784,
   parameter int          T         = 8,
   parameter int          PIX_W     = 8,
   parameter int          IDX_W     = 10,
   parameter logic [11:0] TICK_ADDR = DEF_TICK_ADDR,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             PIX_WE,
   input  logic [IDX_W-1:0] PIX_ADDR,
   input  logic [PIX_W-1:0] PIX_DATA,
   input  logic             START,
   output logic             BUSY,
   output logic             DONE,
   output logic [15:0]      EVT_COUNT,
   output logic [11:0]      AERIN_ADDR,
   output logic             AERIN_REQ,
   input  logic             AERIN_ACK
);

   localparam int               TS_W     = (T > 1) ? $clog2(T) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
   localparam logic [TS_W-1:0]  LAST_TS  = TS_W'(T - 1);

   enc_state_t       state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [TS_W-1:0]  ts_q, ts_d;
   logic             tick_q, tick_d;
   logic             req_d, busy_d, done_d;
   logic [11:0]      addr_d;
   logic [15:0]      evt_d;
   logic             ack_in, ack_q;
   logic             advance;
   logic             spike;
   logic             lfsr_load, lfsr_adv;
   logic [15:0]      lfsr;
   logic             lfsr_unused;
   logic [PIX_W-1:0] pix_q;
   logic [PIX_W-1:0] pix_mem [N];

   aer_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .CLK     (CLK),
      .RST     (RST),
      .load    (lfsr_load),
      .advance (lfsr_adv),
      .state   (lfsr)
   );

   assign lfsr_unused = ^lfsr[15:PIX_W];

   // NOTE: the image array has no reset; its contents must survive RST.
   always_ff @(posedge CLK) begin
      if (PIX_WE && !BUSY && (PIX_ADDR <= LAST_IDX)) pix_mem[PIX_ADDR] <= PIX_DATA;
      if (state_q == ST_FETCH) pix_q <= pix_mem[idx_q];
   end

`ifdef AER_ACK_SYNC_EN
   logic [1:0] ack_sync;
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) ack_sync <= '0;
      else     ack_sync <= {ack_sync[0], AERIN_ACK};
   end
   assign ack_in = ack_sync[1];
`else
   assign ack_in = AERIN_ACK;
`endif

   assign spike = (pix_q == '1) || (lfsr[PIX_W-1:0] < pix_q);

   // NOTE: every always_comb output is defaulted first, so no latch is inferred.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      ts_d      = ts_q;
      tick_d    = tick_q;
      req_d     = AERIN_REQ;
      addr_d    = AERIN_ADDR;
      busy_d    = BUSY;
      done_d    = 1'b0;
      evt_d     = EVT_COUNT;
      lfsr_load = 1'b0;
      lfsr_adv  = 1'b0;
      advance   = 1'b0;

      case (state_q)
         ST_IDLE: if (START) begin
            lfsr_load = 1'b1;
            idx_d     = '0;
            ts_d      = '0;
            tick_d    = 1'b0;
            evt_d     = '0;
            busy_d    = 1'b1;
            state_d   = ST_FETCH;
         end
         ST_FETCH: state_d = ST_EVAL;
         ST_EVAL: begin
            lfsr_adv = 1'b1;
            if (spike) begin
               addr_d  = {SPIKE_PREFIX, idx_q};
               req_d   = 1'b1;
               state_d = ST_REQ;
            end else begin
               advance = 1'b1;
            end
         end
         ST_REQ: if (ack_q) begin
            req_d   = 1'b0;
            state_d = ST_REL;
            if (!tick_q && (EVT_COUNT != 16'hFFFF)) evt_d = EVT_COUNT + 16'd1;
         end
         ST_REL:  if (!ack_q) advance = 1'b1;
         ST_FIN:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Step to the next pixel, the end-of-scan tick, the next scan, or finish.
      if (advance) begin
         if (tick_q) begin
            tick_d = 1'b0;
            if (ts_q != LAST_TS) begin
               ts_d    = ts_q + 1'b1;
               idx_d   = '0;
               state_d = ST_FETCH;
            end else begin
               busy_d  = 1'b0;
               done_d  = 1'b1;
               state_d = ST_FIN;
            end
         end else if (idx_q != LAST_IDX) begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_FETCH;
         end else begin
            tick_d  = 1'b1;
            addr_d  = TICK_ADDR;
            req_d   = 1'b1;
            state_d = ST_REQ;
         end
      end
   end

   // NOTE: blocking (=) only in always_comb; registers update with non-blocking (<=).
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         ts_q       <= '0;
         tick_q     <= 1'b0;
         ack_q      <= 1'b0;
         AERIN_REQ  <= 1'b0;
         AERIN_ADDR <= '0;
         BUSY       <= 1'b0;
         DONE       <= 1'b0;
         EVT_COUNT  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         ts_q       <= ts_d;
         tick_q     <= tick_d;
         ack_q      <= ack_in;
         AERIN_REQ  <= req_d;
         AERIN_ADDR <= addr_d;
         BUSY       <= busy_d;
         DONE       <= done_d;
         EVT_COUNT  <= evt_d;
      end
   end

endmodule

// File: tb/tb_aer_rate_encoder.sv
// Self-checking bench: a T=8 and a T=2 encoder driven from a table of images,
// with a scoreboard of expected AER events and hand-written busy/reset sequences.
module tb_aer_rate_encoder;

   localparam int          N       = 784;
   localparam logic [11:0] TICK    = 12'hFFF;
   localparam int          ACK_LAT = 2;
   localparam int          BUDGET  = 40000;

   typedef struct {
      string       name;
      int          d;
      int          kind;
      logic [7:0]  fill;
      int          sp_idx;
      logic [7:0]  sp_val;
      int          ack_dly;
      int          rel_dly;
      int          exp_spk;
      int          exp_tick;
   } vec_t;

   logic        CLK = 1'b0;
   logic        RST;
   logic [1:0]  start, pix_we, ack, busy, done, req;
   logic [9:0]  pix_addr;
   logic [7:0]  pix_data;
   logic [11:0] addr [2];
   logic [15:0] evt  [2];

   int          n_checks = 0;
   int          n_err    = 0;
   int          model_spk;
   logic [7:0]  img [2][N];
   logic [11:0] exp_q[$];
   logic [11:0] log_q[$];
   logic [11:0] ref_q[$];
   vec_t        vecs [4];

   always #5 CLK = ~CLK;

   aer_rate_encoder #(.T(8)) dut8 (
      .CLK(CLK), .RST(RST), .PIX_WE(pix_we[0]), .PIX_ADDR(pix_addr), .PIX_DATA(pix_data),
      .START(start[0]), .BUSY(busy[0]), .DONE(done[0]), .EVT_COUNT(evt[0]),
      .AERIN_ADDR(addr[0]), .AERIN_REQ(req[0]), .AERIN_ACK(ack[0])
   );

   aer_rate_encoder #(.T(2)) dut2 (
      .CLK(CLK), .RST(RST), .PIX_WE(pix_we[1]), .PIX_ADDR(pix_addr), .PIX_DATA(pix_data),
      .START(start[1]), .BUSY(busy[1]), .DONE(done[1]), .EVT_COUNT(evt[1]),
      .AERIN_ADDR(addr[1]), .AERIN_REQ(req[1]), .AERIN_ACK(ack[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic load_image(input int d, input int kind, input logic [7:0] fill,
                             input int sp_idx, input logic [7:0] sp_val);
      for (int i = 0; i < N; i++) begin
         img[d][i] = (kind == 1) ? 8'(i % 64) : fill;
         if (i == sp_idx) img[d][i] = sp_val;
         @(negedge CLK);
         pix_we[d] = 1'b1;
         pix_addr  = 10'(i);
         pix_data  = img[d][i];
      end
      @(negedge CLK);
      pix_we[d] = 1'b0;
   endtask

   // Reference event sequence: Galois LFSR (mask B400) from seed ACE1, one draw per pixel.
   task automatic model_fill(input int d);
      logic [15:0] l;
      int          scans;
      l         = 16'hACE1;
      model_spk = 0;
      scans     = (d == 0) ? 8 : 2;
      exp_q.delete();
      for (int t = 0; t < scans; t++) begin
         for (int i = 0; i < N; i++) begin
            if (img[d][i] == 8'hFF || l[7:0] < img[d][i]) begin
               exp_q.push_back(12'(i));
               model_spk++;
            end
            l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
         end
         exp_q.push_back(TICK);
      end
   endtask

   task automatic run_sample(input int d, input int ack_dly, input int rel_dly,
                             output int spk, output int tks);
      int          cyc, wait_c, n_done, rel_at;
      logic [11:0] a;
      logic        ok;
      model_fill(d);
      log_q.delete();
      spk = 0; tks = 0; n_done = 0; cyc = 0; rel_at = 0;
      @(negedge CLK); start[d] = 1'b1;
      @(negedge CLK); start[d] = 1'b0;
      check("busy_after_start", busy[d], 1);
      while (n_done == 0 && cyc < BUDGET) begin
         @(negedge CLK); cyc++;
         if (done[d]) begin
            n_done++;
            check("busy_low_at_done", busy[d], 0);
            check("done_after_last_rel", cyc - rel_at, 2);
         end else if (req[d]) begin
            a = addr[d];
            log_q.push_back(a);
            if (exp_q.size() == 0) check("queue_has_event", exp_q.size(), 1);
            else                   check("event_addr", a, exp_q.pop_front());
            if (a == TICK) tks++; else spk++;
            ok = 1'b1;
            repeat (ack_dly) begin
               @(negedge CLK); cyc++;
               ok &= (req[d] === 1'b1) && (addr[d] === a);
            end
            ack[d] = 1'b1;
            wait_c = 0;
            while (req[d] !== 1'b0 && wait_c < 50) begin
               @(negedge CLK); cyc++; wait_c++;
               if (req[d] === 1'b1) ok &= (addr[d] === a);
            end
            check("ack_to_req_low", wait_c, ACK_LAT);
            repeat (rel_dly) begin
               @(negedge CLK); cyc++;
               ok &= (req[d] === 1'b0) && (addr[d] === a);
            end
            ack[d] = 1'b0;
            rel_at = cyc;
            check("handshake_stable", ok, 1);
         end
      end
      check("done_seen", n_done, 1);
      check("queue_empty", exp_q.size(), 0);
      @(negedge CLK);
      check("done_one_cycle", done[d], 0);
   endtask

   task automatic wait_req(input int d, input logic level, output int waited);
      waited = 0;
      while (req[d] !== level && waited < 2000) begin
         @(negedge CLK); waited++;
      end
   endtask

   initial begin
      int spk, tks, want, nmis, w;
      RST = 1'b1; start = '0; pix_we = '0; ack = '0; pix_addr = '0; pix_data = '0;

      vecs[0] = '{"zeros",    0, 0, 8'h00, -1, 8'h00, 7, 7,    0, 8};
      vecs[1] = '{"sat_t2",   1, 0, 8'hFF, -1, 8'h00, 0, 0, 1568, 2};
      vecs[2] = '{"pix5",     0, 0, 8'h00,  5, 8'h80, 0, 20,  -1, 8};
      vecs[3] = '{"gradient", 1, 1, 8'h00, -1, 8'h00, 2, 1,   -1, 2};

      repeat (3) @(negedge CLK);
      for (int d = 0; d < 2; d++) begin
         check("rst_req",  req[d],  0);
         check("rst_addr", addr[d], 0);
         check("rst_busy", busy[d], 0);
         check("rst_done", done[d], 0);
         check("rst_evt",  evt[d],  0);
      end
      RST = 1'b0;
      @(negedge CLK);

      for (int v = 0; v < 4; v++) begin
         load_image(vecs[v].d, vecs[v].kind, vecs[v].fill, vecs[v].sp_idx, vecs[v].sp_val);
         run_sample(vecs[v].d, vecs[v].ack_dly, vecs[v].rel_dly, spk, tks);
         want = (vecs[v].exp_spk >= 0) ? vecs[v].exp_spk : model_spk;
         check({vecs[v].name, "_spikes"},    spk,             want);
         check({vecs[v].name, "_evt_count"}, evt[vecs[v].d], want);
         check({vecs[v].name, "_ticks"},     tks,             vecs[v].exp_tick);
         if (v == 2) ref_q = log_q;
      end

      // Rerun the pix5 image while poking START and a pixel write mid-sample.
      fork
         run_sample(0, 0, 0, spk, tks);
         begin
            repeat (200) @(negedge CLK);
            start[0] = 1'b1; pix_we[0] = 1'b1; pix_addr = 10'd5; pix_data = 8'hFF;
            @(negedge CLK);
            start[0] = 1'b0; pix_we[0] = 1'b0;
         end
      join
      check("busy_prot_spikes", spk, model_spk);
      check("determinism_len", log_q.size(), ref_q.size());
      nmis = 0;
      for (int i = 0; i < log_q.size() && i < ref_q.size(); i++)
         if (log_q[i] !== ref_q[i]) nmis++;
      check("determinism_events", nmis, 0);

      // Three spike handshakes, then reset while the fourth REQ is high.
      @(negedge CLK); start[1] = 1'b1;
      @(negedge CLK); start[1] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         wait_req(1, 1'b1, w);
         ack[1] = 1'b1;
         wait_req(1, 1'b0, w);
         @(negedge CLK); ack[1] = 1'b0;
      end
      wait_req(1, 1'b1, w);
      check("pre_reset_req", req[1], 1);
      check("pre_reset_evt", evt[1], 3);
      #2 RST = 1'b1;
      #1;
      check("mid_rst_req",  req[1],  0);
      check("mid_rst_busy", busy[1], 0);
      check("mid_rst_done", done[1], 0);
      check("mid_rst_evt",  evt[1],  0);
      @(negedge CLK); RST = 1'b0;
      @(negedge CLK);
      run_sample(1, 1, 1, spk, tks);
      check("replay_spikes", spk, model_spk);
      check("replay_evt",    evt[1], model_spk);
      check("replay_ticks",  tks, 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
